// File: rtl/arya_loader_pkg.sv
// Shared definitions for the host loader: opcode and state encodings plus
// default widths for the core memory debug port.
package arya_loader_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_VERIFY = 2'd1,
    OP_RUN    = 2'd2,
    OP_HALT   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VADDR,
    ST_VCMP,
    ST_CRST,
    ST_RUN
  } state_e;

  // Commands that touch core memory and are therefore illegal while the core runs.
  function automatic logic is_mem_op(input op_e op);
    return (op == OP_WRITE) || (op == OP_VERIFY);
  endfunction

endpackage

// File: rtl/arya_host_loader.sv
// Host-side loader: writes and verifies core memory through the debug port,
// then starts/stops the core and counts its run cycles.
module arya_host_loader
  import arya_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] core_mem_data,
  output logic              core_en,
  output logic              core_reset,
  output logic              setup_mem,
  output logic              verify_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              done,
  output logic              match,
  output logic [DATA_W-1:0] last_rd_data,
  output logic [15:0]       mismatch_count,
  output logic [31:0]       cycle_count,
  output logic              err
);

  state_e              r_state;
  state_e              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_done;
  logic                r_match;
  logic [DATA_W-1:0]   r_last_rd_data;
  logic [15:0]         r_mismatch_count;
  logic [31:0]         r_cycle_count;
  logic                r_err;

  op_e                 w_op;
  logic                w_accept;
  logic                w_idle_accept;
  logic                w_illegal;
  logic                w_mismatch;

  assign w_op          = op_e'(cmd_op);
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_idle_accept = w_accept && (r_state == ST_IDLE);
  assign w_illegal     = w_accept && (r_state == ST_RUN) && is_mem_op(w_op);
  assign w_mismatch    = (r_state == ST_VCMP) && (core_mem_data != r_data);

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_WRITE:  w_next = ST_WRITE;
            OP_VERIFY: w_next = ST_VADDR;
            OP_RUN:    w_next = ST_CRST;
            default:   w_next = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_VADDR: w_next = ST_VCMP;
      ST_VCMP:  w_next = ST_IDLE;
      ST_CRST:  w_next = ST_RUN;
      ST_RUN: begin
        // Only HALT leaves RUN; memory ops just raise err, RUN is ignored.
        if (w_accept && (w_op == OP_HALT)) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
    core_en    = (r_state == ST_RUN);
    core_reset = (r_state == ST_CRST);
    setup_mem  = (r_state == ST_WRITE);
    verify_mem = (r_state == ST_VADDR) || (r_state == ST_VCMP);
    mem_addr   = '0;
    mem_data   = '0;
    if (setup_mem) begin
      mem_addr = r_addr;
      mem_data = r_data;
    end else if (verify_mem) begin
      mem_addr = r_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_addr           <= '0;
      r_data           <= '0;
      r_done           <= 1'b0;
      r_match          <= 1'b0;
      r_last_rd_data   <= '0;
      r_mismatch_count <= '0;
      r_cycle_count    <= '0;
      r_err            <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_VCMP);

      // Fields are captured once so later cmd_* changes cannot disturb the op.
      if (w_idle_accept) begin
        r_addr <= cmd_addr;
        r_data <= cmd_data;
      end

      if (r_state == ST_VCMP) begin
        r_last_rd_data <= core_mem_data;
        r_match        <= !w_mismatch;
      end

      if (w_mismatch && (r_mismatch_count != 16'hFFFF)) begin
        r_mismatch_count <= r_mismatch_count + 16'd1;
      end

      if (w_idle_accept && (w_op == OP_RUN)) begin
        r_cycle_count <= '0;
      end else if (r_state == ST_RUN) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end

      if (w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign done           = r_done;
  assign match          = r_match;
  assign last_rd_data   = r_last_rd_data;
  assign mismatch_count = r_mismatch_count;
  assign cycle_count    = r_cycle_count;
  assign err            = r_err;

endmodule

// File: tb/tb_arya_host_loader.sv
// Directed bench for arya_host_loader: table of WRITE/VERIFY transactions
// against a 1-cycle-latency RAM model, plus RUN/HALT, error and reset sequences.
module tb_arya_host_loader;
  import arya_loader_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic [DW-1:0] core_mem_data = '0;
  logic          core_en, core_reset, setup_mem, verify_mem;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          done, match, err;
  logic [DW-1:0] last_rd_data;
  logic [15:0]   mismatch_count;
  logic [31:0]   cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  arya_host_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .core_mem_data(core_mem_data),
    .core_en(core_en), .core_reset(core_reset), .setup_mem(setup_mem), .verify_mem(verify_mem),
    .mem_addr(mem_addr), .mem_data(mem_data), .done(done), .match(match),
    .last_rd_data(last_rd_data), .mismatch_count(mismatch_count),
    .cycle_count(cycle_count), .err(err)
  );

  always #5 clk = ~clk;

  // Core debug RAM: write strobe stores, read select returns data one cycle later.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (setup_mem) ram[mem_addr] <= mem_data;
    if (verify_mem) core_mem_data <= ram[mem_addr];
  end

  typedef struct {
    op_e           op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_match;
    logic [DW-1:0] exp_rd;
    logic [15:0]   exp_mm;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_vec(input vec_t v);
    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_RUN;
    cmd_addr  = ~v.addr;
    cmd_data  = ~v.data;
    check("ready_busy", cmd_ready, 0);
    if (v.op == OP_WRITE) begin
      check("wr_setup_mem", setup_mem, 1);
      check("wr_mem_addr", mem_addr, v.addr);
      check("wr_mem_data", mem_data, v.data);
      check("wr_verify_mem", verify_mem, 0);
      @(negedge clk);
      check("wr_setup_one_cycle", setup_mem, 0);
      check("wr_addr_idle_zero", mem_addr, 0);
      check("wr_ready_back", cmd_ready, 1);
    end else begin
      check("vf_t1_verify_mem", verify_mem, 1);
      check("vf_t1_addr", mem_addr, v.addr);
      check("vf_t1_data_zero", mem_data, 0);
      @(negedge clk);
      check("vf_t2_verify_mem", verify_mem, 1);
      check("vf_t2_addr", mem_addr, v.addr);
      check("vf_t2_no_done", done, 0);
      @(negedge clk);
      check("vf_t3_done", done, 1);
      check("vf_t3_match", match, v.exp_match);
      check("vf_t3_last_rd", last_rd_data, v.exp_rd);
      check("vf_t3_mm_count", mismatch_count, v.exp_mm);
      check("vf_t3_verify_off", verify_mem, 0);
      check("vf_t3_ready", cmd_ready, 1);
      @(negedge clk);
      check("vf_done_one_cycle", done, 0);
    end
  endtask

  task automatic send(input op_e op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_en, n_strobe, n_rst, n_done;
    vec_t sat;

    vecs[0] = '{OP_WRITE,  10'h005, 64'h1122334455667788, 1'b0, 64'h0,                  16'd0};
    vecs[1] = '{OP_VERIFY, 10'h005, 64'h1122334455667788, 1'b1, 64'h1122334455667788,   16'd0};
    vecs[2] = '{OP_VERIFY, 10'h005, 64'h0,                1'b0, 64'h1122334455667788,   16'd1};
    vecs[3] = '{OP_WRITE,  10'h3FF, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0,                  16'd1};
    vecs[4] = '{OP_VERIFY, 10'h3FF, 64'hDEADBEEFCAFEF00D, 1'b1, 64'hDEADBEEFCAFEF00D,   16'd1};
    vecs[5] = '{OP_WRITE,  10'h000, 64'h0123456789ABCDEF, 1'b0, 64'h0,                  16'd1};
    vecs[6] = '{OP_VERIFY, 10'h000, 64'h0123456789ABCDEE, 1'b0, 64'h0123456789ABCDEF,   16'd2};
    vecs[7] = '{OP_VERIFY, 10'h3FF, 64'hDEADBEEFCAFEF00D, 1'b1, 64'hDEADBEEFCAFEF00D,   16'd2};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_WRITE; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_core_en", core_en, 0);
    check("rst_core_reset", core_reset, 0);
    check("rst_setup", setup_mem, 0);
    check("rst_verify", verify_mem, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_err", err, 0);
    check("rst_last_rd", last_rd_data, 0);
    check("rst_mm", mismatch_count, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) do_vec(vecs[i]);

    // Saturation: preload the counter at its ceiling, then mismatch once more.
    @(negedge clk);
    force dut.r_mismatch_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_mismatch_count;
    check("sat_preload", mismatch_count, 16'hFFFF);
    sat = '{OP_VERIFY, 10'h005, 64'h0, 1'b0, 64'h1122334455667788, 16'hFFFF};
    do_vec(sat);

    // RUN for 100 cycles with a stray RUN, WRITE and VERIFY, then HALT.
    check("run_err_clear", err, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("crst_core_reset", core_reset, 1);
    check("crst_core_en", core_en, 0);
    check("crst_cycles_clr", cycle_count, 0);
    check("crst_ready", cmd_ready, 0);
    @(negedge clk);
    check("run_core_reset_off", core_reset, 0);
    n_en = 0; n_strobe = 0; n_rst = 0;
    for (int k = 0; k < 100; k++) begin
      if (core_en) n_en++;
      if (setup_mem || verify_mem) n_strobe++;
      if (core_reset) n_rst++;
      if (k == 41) check("run_ignored_no_clear", cycle_count, 41);
      if (k == 61) begin
        check("run_write_err", err, 1);
        check("run_write_core_en", core_en, 1);
      end
      cmd_valid = (k == 40) || (k == 60) || (k == 70) || (k == 99);
      cmd_addr  = 10'h005;
      cmd_data  = 64'hFFFF_0000_FFFF_0000;
      case (k)
        40:      cmd_op = OP_RUN;
        60:      cmd_op = OP_WRITE;
        70:      cmd_op = OP_VERIFY;
        default: cmd_op = OP_HALT;
      endcase
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("halt_core_en", core_en, 0);
    check("halt_ready", cmd_ready, 1);
    check("halt_cycle_count", cycle_count, 100);
    check("run_en_cycles", n_en, 100);
    check("run_no_strobe", n_strobe, 0);
    check("run_single_crst", n_rst, 0);
    repeat (5) @(negedge clk);
    check("halt_count_holds", cycle_count, 100);

    send(OP_HALT);
    check("idle_halt_core_en", core_en, 0);
    check("idle_halt_crst", core_reset, 0);
    check("idle_halt_ready", cmd_ready, 1);
    check("idle_halt_count", cycle_count, 100);
    check("err_sticky", err, 1);
    check("ram_untouched", ram[10'h005], 64'h1122334455667788);

    // Reset during VADDR aborts the verify; reset then beats a WRITE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_VERIFY; cmd_addr = 10'h005; cmd_data = 64'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_in_vaddr", verify_mem, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_verify_off", verify_mem, 0);
    check("abort_addr_zero", mem_addr, 0);
    check("abort_no_done", done, 0);
    check("abort_err_clr", err, 0);
    check("abort_mm_clr", mismatch_count, 0);
    check("abort_cycles_clr", cycle_count, 0);
    check("abort_last_rd_clr", last_rd_data, 0);
    check("abort_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 10'h007; cmd_data = 64'h55;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b0;
    check("rst_beats_cmd", setup_mem, 0);
    n_done = 0; n_strobe = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) n_done++;
      if (setup_mem || verify_mem) n_strobe++;
    end
    check("abort_no_late_done", n_done, 0);
    check("abort_no_late_strobe", n_strobe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arya_host_loader.md
ARYA_HOST_LOADER -- requirements
Module: arya_host_loader

Interface
REQ-001 SHALL have parameters: DATA_W, 64, memory/data word width; ADDR_W, 10, core memory address width.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all logic rising-edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 cmd_valid  in  1  host command present.
REQ-005 cmd_op  in  2  opcode: 0 WRITE, 1 VERIFY, 2 RUN, 3 HALT.
REQ-006 cmd_addr  in  ADDR_W  target memory address.
REQ-007 cmd_data  in  DATA_W  write data / expected verify data.
REQ-008 cmd_ready  out  1  loader accepts command this cycle.
REQ-009 core_mem_data  in  DATA_W  core debug read data; registered RAM output, 1-cycle latency.
REQ-010 core_en, core_reset, setup_mem, verify_mem  out  1 each  core enable, core reset pulse, memory write strobe, memory debug-read select.
REQ-011 mem_addr  out  ADDR_W; mem_data  out  DATA_W  core debug address/data.
REQ-012 done  out  1  one-cycle pulse when a VERIFY finishes; match  out  1  result of last VERIFY; last_rd_data  out  DATA_W  word read by last VERIFY.
REQ-013 mismatch_count  out  16; cycle_count  out  32; err  out  1  sticky illegal-command flag.

Function
REQ-014 States SHALL be IDLE, WRITE, VADDR, VCMP, CRST, RUN; command accepted only when cmd_valid && cmd_ready.
REQ-015 cmd_ready SHALL be 1 in IDLE and RUN, 0 in all other states.
REQ-016 WRITE accepted at cycle T: at T+1 (state WRITE) setup_mem=1, mem_addr=cmd_addr, mem_data=cmd_data for exactly one cycle; IDLE at T+2.
REQ-017 VERIFY accepted at T: verify_mem=1 and mem_addr=cmd_addr held during T+1 (VADDR) and T+2 (VCMP); core_mem_data sampled at end of T+2.
REQ-018 At T+3: done=1 for one cycle, last_rd_data=sampled word, match=(sampled==cmd_data captured at T), state IDLE.
REQ-019 On mismatch mismatch_count SHALL increment by 1, saturating at 0xFFFF.
REQ-020 RUN accepted in IDLE at T: T+1 state CRST with core_reset=1, core_en=0; from T+2 state RUN with core_en=1; cycle_count cleared at T+1.
REQ-021 cycle_count SHALL increment every cycle core_en=1, wrapping 0xFFFFFFFF->0.
REQ-022 HALT accepted in RUN at T: core_en=0 from T+1, state IDLE; cycle_count holds.
REQ-023 HALT in IDLE SHALL be a no-op; RUN in RUN SHALL be ignored (counter not cleared).
REQ-024 WRITE or VERIFY accepted in RUN SHALL set err=1 and cause no memory access; core keeps running.
REQ-025 setup_mem and verify_mem SHALL never be 1 while core_en=1; mem_addr/mem_data SHALL be 0 when neither strobe is active.
REQ-026 Command fields SHALL be registered on acceptance; later changes on cmd_* SHALL not affect an in-flight command.

Reset
REQ-027 Reset SHALL force IDLE; core_en, core_reset, setup_mem, verify_mem, done, match, err = 0; mem_addr, mem_data, last_rd_data, mismatch_count, cycle_count = 0.
REQ-028 Reset mid-operation SHALL abort the command with no done pulse; reset dominates a simultaneous command.
REQ-029 err and mismatch_count SHALL clear only on reset.

Structure
REQ-030 Opcode encodings, state enum, and DATA_W/ADDR_W defaults SHALL reside in shared package arya_loader_pkg.
REQ-031 Single module; no sub-module required.

Verification
REQ-032 WRITE addr 0x005 data 0x1122334455667788 -> setup_mem=1 exactly one cycle, mem_addr=0x005, cmd_ready low that cycle.
REQ-033 WRITE then VERIFY addr 0x005 expect same -> done at T+3, match=1, last_rd_data=0x1122334455667788, mismatch_count=0.
REQ-034 VERIFY addr 0x005 expect 0 -> match=0, mismatch_count=1; forced count 0xFFFF plus mismatch -> stays 0xFFFF.
REQ-035 RUN, wait 100 cycles, HALT -> core_reset one cycle, core_en high exactly 100 cycles, cycle_count=100.
REQ-036 WRITE during RUN -> err=1, setup_mem stays 0, core_en stays 1; reset asserted in VADDR -> IDLE next cycle, no done, all outputs 0.
